// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, drives the instruction memory address and
// registers the returned word into the IF/ID outputs, trapping bad PCs in a sticky fault.
module instr_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned MEM_BYTES = 1024
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] fetch_addr,
   input  logic [31:0] imem_instr,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_addr,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc_plus4,
   output logic        if_valid,
   output logic        fault,
   output logic [31:0] fault_addr,
   output logic [31:0] fetch_count
);

   localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

   typedef enum logic {
      RUN,
      FAULT
   } state_t;

   state_t      state_q;
   logic [31:0] pc_q;
   logic [31:0] if_instr_q;
   logic [31:0] if_pc_q;
   logic [31:0] if_pc_plus4_q;
   logic        if_valid_q;
   logic        fault_q;
   logic [31:0] fault_addr_q;
   logic [31:0] fetch_count_q;

   logic [31:0] pc_plus4_d;
   logic        pc_bad;

   assign pc_plus4_d = pc_q + 32'd4;
   assign pc_bad     = (pc_q[1:0] != 2'b00) || (pc_q >= MEM_LIMIT);

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   // NOTE: every register is reset here; there is no memory array in this block to exclude.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= RUN;
         pc_q          <= RESET_PC;
         if_instr_q    <= '0;
         if_pc_q       <= '0;
         if_pc_plus4_q <= '0;
         if_valid_q    <= 1'b0;
         fault_q       <= 1'b0;
         fault_addr_q  <= '0;
         fetch_count_q <= '0;
      end else begin
         unique case (state_q)
            RUN: begin
               // A redirect wins even over a bad current PC; the new target is checked once it is pc.
               if (redirect_valid) begin
                  pc_q       <= redirect_addr;
                  if_valid_q <= 1'b0;
                  if_instr_q <= '0;
               end else if (stall) begin
                  pc_q <= pc_q;
               end else if (pc_bad) begin
                  state_q      <= FAULT;
                  fault_q      <= 1'b1;
                  fault_addr_q <= pc_q;
                  if_valid_q   <= 1'b0;
                  if_instr_q   <= '0;
               end else begin
                  if_instr_q    <= imem_instr;
                  if_pc_q       <= pc_q;
                  if_pc_plus4_q <= pc_plus4_d;
                  if_valid_q    <= 1'b1;
                  pc_q          <= pc_plus4_d;
                  fetch_count_q <= fetch_count_q + 32'd1;
               end
            end
            FAULT: begin
               if_valid_q <= 1'b0;
            end
            default: state_q <= FAULT;
         endcase
      end
   end

   assign fetch_addr  = pc_q;
   assign if_instr    = if_instr_q;
   assign if_pc       = if_pc_q;
   assign if_pc_plus4 = if_pc_plus4_q;
   assign if_valid    = if_valid_q;
   assign fault       = fault_q;
   assign fault_addr  = fault_addr_q;
   assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a ROM model feeds the fetch stage and a scoreboard
// queue of expected (pc, instruction) pairs is compared whenever fetch_count advances.
module tb_instr_fetch;

   logic        clk;
   logic        reset;
   logic [31:0] fetch_addr;
   logic [31:0] imem_instr;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_addr;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus4;
   logic        if_valid;
   logic        fault;
   logic [31:0] fault_addr;
   logic [31:0] fetch_count;

   instr_fetch #(.RESET_PC(32'h0000_0000), .MEM_BYTES(1024)) dut (
      .clk            (clk),
      .reset          (reset),
      .fetch_addr     (fetch_addr),
      .imem_instr     (imem_instr),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .if_pc_plus4    (if_pc_plus4),
      .if_valid       (if_valid),
      .fault          (fault),
      .fault_addr     (fault_addr),
      .fetch_count    (fetch_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] mem [256];
   assign imem_instr = (fetch_addr < 32'd1024) ? mem[fetch_addr[9:2]] : 32'hDEAD_BEEF;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t        sb[$];
   int          n_total = 0;
   int          n_pass  = 0;
   logic [31:0] last_count = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic push_fetch(input logic [31:0] addr);
      exp_t e;
      e.pc    = addr;
      e.instr = mem[addr[9:2]];
      sb.push_back(e);
   endtask

   // One clock edge, sampled 1 time unit later; any newly latched fetch is scored.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      if (fetch_count !== last_count) begin
         if (sb.size() == 0) begin
            check("unexpected_fetch", fetch_count, last_count);
         end else begin
            e = sb.pop_front();
            check("sb_instr", if_instr, e.instr);
            check("sb_pc", if_pc, e.pc);
            check("sb_pc_plus4", if_pc_plus4, e.pc + 32'd4);
            check("sb_valid", {31'd0, if_valid}, 32'd1);
         end
         last_count = fetch_count;
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 + 32'(i);
      mem[0] = 32'h11;
      mem[1] = 32'h22;
      mem[2] = 32'h33;
      mem[3] = 32'h44;

      reset          = 1'b1;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_addr  = '0;
      #2;
      check("rst_fetch_addr", fetch_addr, 32'h0);
      check("rst_if_valid", {31'd0, if_valid}, 32'd0);
      check("rst_if_instr", if_instr, 32'h0);
      check("rst_fault", {31'd0, fault}, 32'd0);
      check("rst_fetch_count", fetch_count, 32'd0);
      #5 reset = 1'b0;

      // Sequential fetch of words 0..2.
      push_fetch(32'd0);
      push_fetch(32'd4);
      push_fetch(32'd8);
      repeat (3) tick();
      check("seq_count", fetch_count, 32'd3);

      // Stall holds everything while if_pc=8.
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_instr", if_instr, 32'h33);
         check("stall_pc", if_pc, 32'd8);
         check("stall_fetch_addr", fetch_addr, 32'd12);
         check("stall_valid", {31'd0, if_valid}, 32'd1);
      end
      stall = 1'b0;
      push_fetch(32'd12);
      tick();
      check("resume_count", fetch_count, 32'd4);

      // Redirect together with stall: redirect wins and inserts a bubble.
      stall          = 1'b1;
      redirect_valid = 1'b1;
      redirect_addr  = 32'h40;
      tick();
      check("redir_valid", {31'd0, if_valid}, 32'd0);
      check("redir_instr", if_instr, 32'h0);
      check("redir_fetch_addr", fetch_addr, 32'h40);
      stall          = 1'b0;
      redirect_valid = 1'b0;
      push_fetch(32'h40);
      tick();
      check("redir_count", fetch_count, 32'd5);

      // Misaligned redirect target faults one edge after it becomes pc.
      redirect_valid = 1'b1;
      redirect_addr  = 32'h42;
      tick();
      check("mis_fetch_addr", fetch_addr, 32'h42);
      check("mis_valid_bubble", {31'd0, if_valid}, 32'd0);
      redirect_valid = 1'b0;
      tick();
      check("mis_fault", {31'd0, fault}, 32'd1);
      check("mis_fault_addr", fault_addr, 32'h42);
      check("mis_valid", {31'd0, if_valid}, 32'd0);
      redirect_valid = 1'b1;
      redirect_addr  = 32'h0;
      tick();
      check("fault_sticky", {31'd0, fault}, 32'd1);
      check("fault_pc_hold", fetch_addr, 32'h42);
      check("fault_count_hold", fetch_count, 32'd5);
      redirect_valid = 1'b0;

      // Asynchronous reset between edges while faulted.
      #3 reset = 1'b1;
      #1;
      check("arst_fault", {31'd0, fault}, 32'd0);
      check("arst_valid", {31'd0, if_valid}, 32'd0);
      check("arst_count", fetch_count, 32'd0);
      check("arst_fetch_addr", fetch_addr, 32'h0);
      last_count = '0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      push_fetch(32'd0);
      tick();

      // Last word of memory: latched, then the sequential pc of 1024 faults.
      redirect_valid = 1'b1;
      redirect_addr  = 32'd1020;
      tick();
      redirect_valid = 1'b0;
      push_fetch(32'd1020);
      tick();
      check("end_fetch_addr", fetch_addr, 32'd1024);
      tick();
      check("end_fault", {31'd0, fault}, 32'd1);
      check("end_fault_addr", fault_addr, 32'd1024);
      check("end_valid", {31'd0, if_valid}, 32'd0);
      check("end_count", fetch_count, 32'd2);

      check("sb_drain", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage that drives the instruction memory: owns the program counter and issues word-aligned byte addresses.
- Captures the returned 32-bit instruction into an IF/ID output register with a valid flag.
- Supports stall and branch/jump redirect, and traps out-of-range or misaligned PCs in a sticky fault state.
- Sits between the asynchronous instruction ROM (256 words, 1024 bytes) and the decode stage.

Parameters:
RESET_PC, 32'h0000_0000, byte address fetched first after reset
MEM_BYTES, 1024, size of instruction memory in bytes; valid PCs are 0..MEM_BYTES-4, multiples of 4

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
fetch_addr  output  32  byte address to instruction memory; combinationally equal to pc
imem_instr  input  32  instruction returned combinationally by memory for fetch_addr
stall  input  1  hold pc and IF/ID outputs this cycle
redirect_valid  input  1  load redirect_addr into pc this cycle (branch/jump taken)
redirect_addr  input  32  new byte address
if_instr  output  32  registered instruction
if_pc  output  32  byte address of if_instr
if_pc_plus4  output  32  if_pc + 4
if_valid  output  1  if_instr/if_pc hold a real fetched instruction
fault  output  1  sticky fetch fault
fault_addr  output  32  pc value that caused the fault
fetch_count  output  32  number of instructions latched with if_valid=1 since reset

Behaviour:
- States: RUN, FAULT. Reset -> RUN.
- Reset (async, immediate): pc=RESET_PC, if_instr=0, if_pc=0, if_pc_plus4=0, if_valid=0, fault=0, fault_addr=0, fetch_count=0. Asserting reset mid-operation discards all state.
- pc_bad = (pc[1:0]!=0) or (pc >= MEM_BYTES), using an unsigned compare.
- RUN, per rising edge, highest priority first:
  1. redirect_valid=1: pc<=redirect_addr; if_valid<=0; if_instr<=0 (bubble). Redirect overrides stall and pc_bad; redirect_addr is not checked until it becomes pc.
  2. stall=1: all registers hold; if_valid keeps its value.
  3. pc_bad=1: state<=FAULT; fault<=1; fault_addr<=pc; if_valid<=0; if_instr<=0; pc holds.
  4. Otherwise: if_instr<=imem_instr; if_pc<=pc; if_pc_plus4<=pc+4; if_valid<=1; pc<=pc+4; fetch_count<=fetch_count+1.
- FAULT: sticky until reset. pc, fault_addr and fetch_count hold; if_valid=0; redirect_valid and stall are ignored. fetch_addr still drives pc.
- Latency: instruction at address A appears on if_instr one edge after pc==A with no stall and no redirect. Sustained throughput is one instruction per cycle.
- Arithmetic: pc+4 and fetch_count wrap modulo 2^32 with no saturation. Sequential fetch from MEM_BYTES-4 yields pc=MEM_BYTES, which faults on the next edge.
- fetch_addr never depends on imem_instr, so there is no combinational loop.

Test Plan:
- Reset release with memory words 0..3 = 0x11,0x22,0x33,0x44 -> on edges 1..4: if_instr=0x11,0x22,0x33,0x44; if_pc=0,4,8,12; if_valid=1; fetch_count=4.
- stall=1 for 3 cycles while if_pc=8 -> if_instr=0x33, if_pc=8, fetch_addr=12 all held; resumes with 0x44 at if_pc=12 one edge after stall drops.
- redirect_valid=1, redirect_addr=0x40 with stall=1 in the same cycle -> next edge if_valid=0, if_instr=0, fetch_addr=0x40; following edge if_pc=0x40, if_valid=1.
- Redirect to 0x42 -> next edge pc=0x42; following edge fault=1, fault_addr=0x42, if_valid=0; a later redirect to 0x0 is ignored and fault stays 1.
- Redirect to 1020 -> instruction at 1020 latched; next edge fault=1, fault_addr=1024.
- Assert reset asynchronously between clock edges during a fault -> fault, if_valid and fetch_count go to 0 immediately and fetch_addr=RESET_PC; the first edge after release latches the word at RESET_PC.
